muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with the architectural HI/LO registers. It sits beside the main ALU in the MIPS datapath and is driven by the SPECIAL-opcode function field. It executes MULT, MULTU, DIV and DIVU iteratively over WIDTH+1 cycles, and MTHI/MTLO in a single cycle. It exposes `busy` so the control unit can stall MFHI/MFLO and any further mult/div op until the result is committed.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; even, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; one clock, no other clock domains.
- `start`  in  1  issue strobe; the instruction is SPECIAL and `func_code` is valid this cycle.
- `func_code`  in  6  function field.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- `op_a`  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data.
- `op_b`  in  WIDTH  rt value: multiplier or divisor.
- `busy`  out  1  registered; high while a mult/div is in flight.
- `done`  out  1  registered one-cycle pulse; HI/LO were updated on the preceding edge.
- `hi`  out  WIDTH  HI register, read directly for MFHI.
- `lo`  out  WIDTH  LO register, read directly for MFLO.

## Operation
- **States**
  - IDLE: waits for an accepted op.
  - RUN: WIDTH iterations, counter 0..WIDTH-1.
  - FIX: sign correction and HI/LO commit, then back to IDLE.
- **Accept rule:** `start` is accepted only when state is IDLE.
  - `start` while busy is ignored entirely. The control unit guarantees a stall; the unit does not queue.
  - MFHI/MFLO and undefined function codes with `start` are no-ops: no state change, `busy` stays 0.
- **MTHI/MTLO** (IDLE only): `hi` or `lo` ← `op_a` on the accept edge. The other register is unchanged. No `busy`, no `done`.
- **Accept edge for MULT/DIV family**
  - Latch the operands as magnitudes. For signed ops (MULT, DIV) take the two's-complement absolute value; for unsigned ops use the raw value.
  - Latch the sign flags: quotient/product sign = sign(a) XOR sign(b); remainder sign = sign(a). Sign flags are zero for unsigned ops.
  - Clear the 2·WIDTH accumulator and go to RUN.
- **Multiply:** shift-add, one multiplier bit per cycle, LSB first, into a 2·WIDTH accumulator.
- **Divide:** restoring, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder.
- **FIX**
  - Negate the product (2·WIDTH bits) if the product sign is set; hi = upper WIDTH bits, lo = lower.
  - For divide: lo = quotient, negated if the quotient sign is set; hi = remainder, negated if the remainder sign is set.
- **Division by zero:** `lo` = all ones, `hi` = `op_a` as originally presented (unsigned/raw). Same latency; no exception.
- **Signed overflow** (most-negative ÷ −1): `lo` = 100…0, `hi` = 0. This falls out of the magnitude algorithm and needs no special case.
- HI/LO are not modified during RUN. Intermediate state lives only in internal registers.

## Timing
- **Reset:** state IDLE, counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0. Reset takes effect immediately, including mid-RUN/FIX; the in-flight op is discarded.
- **Edge numbering:** accept edge E0. `busy` rises after E0. RUN occupies edges E1..E_WIDTH. FIX commits HI/LO on E_{WIDTH+1}.
- **After E_{WIDTH+1}:** `busy`=0 and `done`=1, for exactly one cycle.
  - Total latency is WIDTH+1 edges (33 at WIDTH=32).
- **Back-to-back ops:** a new `start` may be accepted on the edge where `done` is high. HI/LO are already valid in that cycle.
- **MTHI/MTLO:** the value is visible on `hi`/`lo` the cycle after the accept edge.
- `busy` and `done` are never high together.

## Test plan
- **MULTU, unsigned extremes:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `done` one cycle, 33 edges after accept; `busy` high for exactly 33 cycles.
- **MULT, mixed signs:** MULT −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- **Signed divide:** DIV −7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **Unsigned divide:** DIVU 100 ÷ 7 → lo=0x0000000E, hi=0x00000002.
- **Divide corners:**
  - DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 5 ÷ 0 → lo=0xFFFFFFFF, hi=0x00000005.
- **Moves and ignored issues:**
  - MTHI 0x12345678 while idle → hi=0x12345678 next cycle, `busy` stays 0.
  - MTLO with `start` while busy → ignored; lo unchanged at `done`.
  - MULT with `start` 5 cycles into a DIV → ignored; the DIV result is committed.
- **Reset mid-operation:** assert `reset` 10 cycles into a DIVU → `busy`=0, `done`=0, hi=lo=0 without waiting for a clock edge. A fresh MULTU 2×3 after release gives lo=6, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles. MTHI/MTLO complete in one cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [5:0] FnMthi = 6'b010001;
  localparam logic [5:0] FnMtlo = 6'b010011;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     rem_q;
  // Multiply: mag_q = |a| (multiplicand), sh_q = |b| (multiplier).
  // Divide:   mag_q = |b| (divisor),      sh_q = |a| (dividend).
  logic [WIDTH-1:0]   mag_q;
  logic [WIDTH-1:0]   sh_q;
  logic               is_div_q;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero_q;

  logic               is_md;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    is_md     = (func_code[5:2] == 4'b0110);
    signed_op = ~func_code[0];
    a_neg     = signed_op & op_a[WIDTH-1];
    b_neg     = signed_op & op_b[WIDTH-1];
    abs_a     = a_neg ? (~op_a + 1'b1) : op_a;
    abs_b     = b_neg ? (~op_b + 1'b1) : op_b;

    addend    = sh_q[0] ? mag_q : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    div_shift = {rem_q[WIDTH-1:0], sh_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_q};
    div_ge    = ~div_diff[WIDTH+1];

    prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    rem_fix   = neg_r ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    if (div_zero_q) begin
      quo_fix = '1;
    end else begin
      quo_fix = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      mag_q      <= '0;
      sh_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (func_code == FnMthi) begin
              hi <= op_a;
            end else if (func_code == FnMtlo) begin
              lo <= op_a;
            end else if (is_md) begin
              state_q    <= StRun;
              busy       <= 1'b1;
              cnt_q      <= '0;
              acc_q      <= '0;
              rem_q      <= '0;
              is_div_q   <= func_code[1];
              neg_q      <= a_neg ^ b_neg;
              neg_r      <= a_neg;
              div_zero_q <= (op_b == '0);
              mag_q      <= func_code[1] ? abs_b : abs_a;
              sh_q       <= func_code[1] ? abs_a : abs_b;
            end
          end
        end
        StRun: begin
          if (is_div_q) begin
            rem_q <= div_ge ? div_diff[WIDTH:0] : div_shift;
            sh_q  <= sh_q << 1;
            acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
            sh_q  <= sh_q >> 1;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          if (is_div_q) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO and completion cycle are queued at issue
// and checked by an independent monitor whenever done is seen.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010;
  localparam logic [5:0] DIVU = 6'b011011;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   func_code = 6'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .func_code(func_code),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation whenever done is presented.
  always @(negedge clk) begin
    exp_t e;
    if (busy && done) begin
      errors++;
      $display("FAIL busy_and_done actual=1 required=0 at cycle %0d", cyc);
    end
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_cycle"}, W'(cyc), W'(e.due));
      end
    end
  end

  // Drives one issue cycle; returns 1 time unit after the accept edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; func_code = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; func_code = 6'b0;
  endtask

  task automatic issue_md(input string name, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    e.name = name; e.hi = eh; e.lo = el; e.due = cyc + W + 2;
    sb.push_back(e);
    issue(f, a, b);
  endtask

  // Waits on negedges until busy drops; returns the number of busy cycles seen.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle_timeout actual=busy required=idle");
  endtask

  initial begin
    int n;
    #2;
    check("reset_busy", W'(busy), 0);
    check("reset_done", W'(done), 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    issue_md("multu_ext", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    wait_idle(n);
    check("multu_busy_cycles", W'(n), 33);

    issue_md("mult_neg", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    wait_idle(n);
    issue_md("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle(n);
    issue_md("divu", DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
    wait_idle(n);
    issue_md("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    wait_idle(n);
    issue_md("mult_big", MULT, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
    wait_idle(n);
    issue_md("div_neg_by0", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    wait_idle(n);
    issue_md("divu_by0", DIVU, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
    wait_idle(n);

    issue(MTHI, 32'h12345678, 32'h0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo_kept", lo, 32'hFFFFFFFF);
    check("mthi_busy", W'(busy), 0);
    issue(MFHI, 32'hAAAA5555, 32'h0);
    check("mfhi_busy", W'(busy), 0);
    check("mfhi_hi_kept", hi, 32'h12345678);
    issue(MTLO, 32'h00C0FFEE, 32'h0);
    check("mtlo_lo", lo, 32'h00C0FFEE);

    issue_md("divu_mtlo_ignored", DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
    repeat (3) @(negedge clk);
    issue(MTLO, 32'hDEADBEEF, 32'h0);
    wait_idle(n);

    issue_md("div_mult_ignored", DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);
    repeat (4) @(negedge clk);
    issue(MULT, 32'd9, 32'd9);
    wait_idle(n);

    issue_md("divu_reset", DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check("midreset_busy", W'(busy), 0);
    check("midreset_done", W'(done), 0);
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    issue_md("multu_after_reset", MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
    wait_idle(n);
    // Back-to-back: issued on the negedge where done is high.
    issue_md("mult_b2b", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1);
    wait_idle(n);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", W'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
